rom_read_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for a small synchronous-read memory array. The array is a registered ROM with one read port and one-cycle read latency; its data register updates on every `clk` edge where `mem_en` is high. The block grants one requester at a time, drives the array's address and enable, and captures the returned word. It returns the word on a shared data bus with a per-requester acknowledge pulse. It sits between the array and its consumers so that the array needs only one read port.

---
 rtl/rom_read_arbiter_if.sv | 28 ++
 rtl/rom_read_arbiter.sv | 78 +++++++
 tb/tb_rom_read_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rom_read_arbiter_if.sv
// Bundle between rom_read_arbiter and its two requesters plus the ROM array.
// master: requesters/array side; slave: the arbiter.
interface rom_read_arbiter_if #(
    parameter int ADDR_W = 1,
    parameter int DATA_W = 4
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output req0, addr0, req1, addr1, mem_data,
        input  ack0, ack1, rdata, busy, mem_addr, mem_en
    );

    modport slave (
        input  req0, addr0, req1, addr1, mem_data,
        output ack0, ack1, rdata, busy, mem_addr, mem_en
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter/sequencer giving two requesters reads from a
// single-port registered ROM. Ports: clk, rst_n, bus (slave modport).
module rom_read_arbiter #(
    parameter int ADDR_W = 1,
    parameter int DATA_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    rom_read_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPT,
        ACK
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              last;
    logic              owner;
    logic              grant1;
    logic              any_req;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ack0_q;
    logic              ack1_q;

    // last=1 means requester 1 was served most recently, so 0 wins a tie
    always_comb begin
        any_req = bus.req0 | bus.req1;
        grant1  = bus.req1 & (~bus.req0 | ~last);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = READ;
            READ:    state_nx = CAPT;
            CAPT:    state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last       <= 1'b1;
            owner      <= 1'b0;
            mem_addr_q <= '0;
            rdata_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                owner      <= grant1;
                last       <= grant1;
                mem_addr_q <= grant1 ? bus.addr1 : bus.addr0;
            end
            if (state == CAPT) rdata_q <= bus.mem_data;
            // acks are set on the CAPT->ACK edge and cleared on the next one
            ack0_q <= (state == CAPT) && !owner;
            ack1_q <= (state == CAPT) && owner;
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_en   = (state == READ);
    assign bus.busy     = (state != IDLE);
    assign bus.rdata    = rdata_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: ROM model mem[0]=2, mem[1]=1,
// table-driven per-cycle vectors plus hand-written multi-cycle sequences.
module tb_rom_read_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rom_read_arbiter_if #(.ADDR_W(1), .DATA_W(4)) bus_i ();

    rom_read_arbiter #(.ADDR_W(1), .DATA_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_i)
    );

    logic [3:0] rom [2];
    initial begin
        rom[0] = 4'h2;
        rom[1] = 4'h1;
        bus_i.mem_data = 4'h0;
    end

    always @(posedge clk)
        if (bus_i.mem_en) bus_i.mem_data <= rom[bus_i.mem_addr];

    // packed outputs: {ack0, ack1, rdata[3:0], busy, mem_en, mem_addr}
    function automatic logic [8:0] outs();
        return {bus_i.ack0, bus_i.ack1, bus_i.rdata,
                bus_i.busy, bus_i.mem_en, bus_i.mem_addr};
    endfunction

    task automatic chk(input string name, input logic [8:0] act,
                       input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (ack0 ack1 rdata busy en addr)",
                     name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic a0,
                         input logic r1, input logic a1);
        bus_i.req0  = r0;
        bus_i.addr0 = a0;
        bus_i.req1  = r1;
        bus_i.addr1 = a1;
    endtask

    // leaves time at 1 unit after the posedge that starts cycle 0
    task automatic do_reset();
        drive(0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("reset_state", outs(), 9'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       first;
        logic       r0;
        logic       a0;
        logic       r1;
        logic       a1;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [8:0] e(input logic k0, input logic k1,
                                     input logic [3:0] d, input logic b,
                                     input logic en, input logic ad);
        return {k0, k1, d, b, en, ad};
    endfunction

    initial begin
        // single req0 at address 1
        vecs[0]  = '{1, 1, 1, 0, 0, e(0, 0, 4'h0, 0, 0, 0)};
        vecs[1]  = '{0, 1, 1, 0, 0, e(0, 0, 4'h0, 1, 1, 1)};
        vecs[2]  = '{0, 1, 1, 0, 0, e(0, 0, 4'h0, 1, 0, 1)};
        vecs[3]  = '{0, 1, 1, 0, 0, e(1, 0, 4'h1, 1, 0, 1)};
        vecs[4]  = '{0, 0, 1, 0, 0, e(0, 0, 4'h1, 0, 0, 1)};
        // simultaneous requests: 0 first, then 1
        vecs[5]  = '{1, 1, 0, 1, 1, e(0, 0, 4'h0, 0, 0, 0)};
        vecs[6]  = '{0, 1, 0, 1, 1, e(0, 0, 4'h0, 1, 1, 0)};
        vecs[7]  = '{0, 1, 0, 1, 1, e(0, 0, 4'h0, 1, 0, 0)};
        vecs[8]  = '{0, 1, 0, 1, 1, e(1, 0, 4'h2, 1, 0, 0)};
        vecs[9]  = '{0, 0, 0, 1, 1, e(0, 0, 4'h2, 0, 0, 0)};
        vecs[10] = '{0, 0, 0, 1, 1, e(0, 0, 4'h2, 1, 1, 1)};
        vecs[11] = '{0, 0, 0, 1, 1, e(0, 0, 4'h2, 1, 0, 1)};
        vecs[12] = '{0, 0, 0, 1, 1, e(0, 1, 4'h1, 1, 0, 1)};
        vecs[13] = '{0, 0, 0, 0, 1, e(0, 0, 4'h1, 0, 0, 1)};
        // req1 at addr 0; addr moves and req drops in READ
        vecs[14] = '{1, 0, 0, 1, 0, e(0, 0, 4'h0, 0, 0, 0)};
        vecs[15] = '{0, 0, 0, 0, 1, e(0, 0, 4'h0, 1, 1, 0)};
        vecs[16] = '{0, 0, 0, 0, 1, e(0, 0, 4'h0, 1, 0, 0)};
        vecs[17] = '{0, 0, 0, 0, 1, e(0, 1, 4'h2, 1, 0, 0)};
        vecs[18] = '{0, 0, 0, 0, 1, e(0, 0, 4'h2, 0, 0, 0)};

        drive(0, 0, 0, 0);
        #1;

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].first) begin
                do_reset();
            end else begin
                @(posedge clk);
                #1;
            end
            drive(vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1);
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // continuous requests: acks alternate every 4 cycles
        do_reset();
        drive(1, 1, 1, 0);
        for (int k = 0; k < 16; k++) begin
            logic x0;
            logic x1;
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            x0 = (k % 8 == 3);
            x1 = (k % 8 == 7);
            checks++;
            if (bus_i.ack0 !== x0 || bus_i.ack1 !== x1) begin
                errors++;
                $display("FAIL rr_ack cyc%0d: got %b%b expected %b%b",
                         k, bus_i.ack0, bus_i.ack1, x0, x1);
            end
            if (x0 || x1) begin
                checks++;
                if (bus_i.rdata !== (x0 ? 4'h1 : 4'h2)) begin
                    errors++;
                    $display("FAIL rr_rdata cyc%0d: got %h expected %h",
                             k, bus_i.rdata, x0 ? 4'h1 : 4'h2);
                end
            end
        end

        // reset asserted in CAPT aborts the transaction
        do_reset();
        drive(1, 1, 0, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("capt_before_rst", outs(), e(0, 0, 4'h0, 1, 0, 1));
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        chk("rst_in_capt", outs(), 9'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("no_ack_after_rst%0d", k), outs(), 9'b0);
        end
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            logic [8:0] x;
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k == 4) drive(0, 0, 0, 0);
            @(negedge clk);
            unique case (k)
                0: x = e(0, 0, 4'h0, 0, 0, 0);
                1: x = e(0, 0, 4'h0, 1, 1, 0);
                2: x = e(0, 0, 4'h0, 1, 0, 0);
                3: x = e(1, 0, 4'h2, 1, 0, 0);
                default: x = e(0, 0, 4'h2, 0, 0, 0);
            endcase
            chk($sformatf("post_rst_req%0d", k), outs(), x);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
